nes_pad_reader: RTL



---
 rtl/nes_pad_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nes_pad_reader.sv
// Host-side NES controller (CD4021) poller: periodically latches the pad, clocks out
// 8 button bits plus a presence bit, and publishes an active-high button byte.
module nes_pad_reader #(
   parameter int unsigned HALF_CYCLES   = 300,
   parameter int unsigned LATCH_CYCLES  = 600,
   parameter int unsigned POLL_INTERVAL = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic       pad_present,
   output logic       valid,
   output logic       busy
);

   localparam int unsigned TMR_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned CNT_W   = $clog2(POLL_INTERVAL + 1);

   localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(LATCH_CYCLES - 1);
   localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_CYCLES - 1);
   localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_INTERVAL - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StSettle,
      StClkHi,
      StClkLo,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [8:0]       shift_q, shift_d;
   logic [1:0]       sync_q;
   logic             sync;
   logic             half_done;
   logic [7:0]       buttons_d;
   logic             pad_present_d;

   assign sync      = sync_q[1];
   assign half_done = (timer_q == HALF_LAST);

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q + TMR_W'(1);
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      buttons_d     = buttons;
      pad_present_d = pad_present;

      if (!enable) begin
         poll_cnt_d = '0;
      end else if (poll_cnt_q == POLL_LAST) begin
         poll_cnt_d = '0;
      end else begin
         poll_cnt_d = poll_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (enable && (poll_cnt_q == POLL_LAST)) begin
               state_d = StLatch;
            end
         end
         StLatch: begin
            if (timer_q == LATCH_LAST) begin
               state_d = StSettle;
               timer_d = '0;
            end
         end
         StSettle: begin
            // First sample (A) is already on the pad output once the latch drops.
            if (half_done) begin
               shift_d   = {~sync, shift_q[8:1]};
               bit_idx_d = '0;
               state_d   = StClkHi;
               timer_d   = '0;
            end
         end
         StClkHi: begin
            if (half_done) begin
               state_d = StClkLo;
               timer_d = '0;
            end
         end
         StClkLo: begin
            if (half_done) begin
               shift_d   = {~sync, shift_q[8:1]};
               bit_idx_d = (bit_idx_q == 4'd8) ? 4'd8 : bit_idx_q + 4'd1;
               timer_d   = '0;
               state_d   = (bit_idx_q == 4'd7) ? StDone : StClkHi;
            end
         end
         StDone: begin
            state_d = StIdle;
            timer_d = '0;
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase

      // Publish together with valid; 9th sample stored inverted, so 1 means raw low.
      if (state_d == StDone) begin
         buttons_d     = shift_d[7:0];
         pad_present_d = shift_d[8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         poll_cnt_q  <= '0;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         sync_q      <= 2'b11;
         pad_latch   <= 1'b0;
         pad_clk     <= 1'b0;
         buttons     <= 8'h00;
         pad_present <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         poll_cnt_q  <= poll_cnt_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         sync_q      <= {sync_q[0], pad_data};
         pad_latch   <= (state_d == StLatch);
         pad_clk     <= (state_d == StClkHi);
         buttons     <= buttons_d;
         pad_present <= pad_present_d;
         valid       <= (state_d == StDone);
         busy        <= (state_d != StIdle);
      end
   end

endmodule
